// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - fetch, decoder and execute-strobe bundle of the multicycle controller
interface multicycle_controller_if;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [2:0]  alu_op;
  logic        is_jump;
  logic        is_beq;
  logic [31:0] imm;
  logic [4:0]  reg_dst;
  logic        regs_equal;
  logic        alu_en;
  logic        rf_we;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  run, imem_ack, imem_rdata, alu_op, is_jump, is_beq, imm, reg_dst, regs_equal,
    output imem_req, pc, ir, alu_en, rf_we, state, instr_count
  );

  modport slave (
    output run, imem_ack, imem_rdata, alu_op, is_jump, is_beq, imm, reg_dst, regs_equal,
    input  imem_req, pc, ir, alu_en, rf_we, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/WB sequencer with pc, ir and retire counter
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, alu_en_q, rf_we_q;
  logic        retire;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      IDLE:   if (bus.run) state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        // Jump beats branch; only plain ALU ops spend a cycle in WB.
        if (bus.is_jump) begin
          pc_d   = pc_q + bus.imm;
          retire = 1'b1;
        end else if (bus.is_beq) begin
          pc_d   = bus.regs_equal ? pc_q + bus.imm : pc_q + 32'd1;
          retire = 1'b1;
        end else if (bus.alu_op >= 3'b010) begin
          state_d = WB;
        end else begin
          pc_d   = pc_q + 32'd1;
          retire = 1'b1;
        end
      end
      WB: begin
        pc_d   = pc_q + 32'd1;
        retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (retire) begin
      cnt_d   = cnt_q + 32'd1;
      state_d = bus.run ? FETCH : IDLE;
    end
  end

  // Strobes are registered from the next state so they align exactly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= 32'd0;
      ir_q     <= 32'd0;
      cnt_q    <= 32'd0;
      req_q    <= 1'b0;
      alu_en_q <= 1'b0;
      rf_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      req_q    <= (state_d == FETCH);
      alu_en_q <= (state_d == EXEC);
      rf_we_q  <= (state_d == WB) && (bus.reg_dst != 5'd0);
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.instr_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench with instruction-phase reference model
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;

  // Reference: phase 0 idle, 1 fetching, 2 decoding, 3 executing, 4 writing back.
  int          m_ph;
  logic [31:0] m_pc, m_ir, m_cnt;

  function automatic logic [31:0] pc_step(input int ph);
    if (ph == 4) return 32'd1;
    if (bus.is_jump) return bus.imm;
    if (bus.is_beq) return bus.regs_equal ? bus.imm : 32'd1;
    return 32'd1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph  <= 0;
      m_pc  <= 32'd0;
      m_ir  <= 32'd0;
      m_cnt <= 32'd0;
    end else if (m_ph == 0) begin
      if (bus.run) m_ph <= 1;
    end else if (m_ph == 1) begin
      if (bus.imem_ack) begin
        m_ir <= bus.imem_rdata;
        m_ph <= 2;
      end
    end else if (m_ph == 2) begin
      m_ph <= 3;
    end else if (m_ph == 3 && !bus.is_jump && !bus.is_beq && bus.alu_op >= 3'd2) begin
      m_ph <= 4;
    end else begin
      m_pc  <= m_pc + pc_step(m_ph);
      m_cnt <= m_cnt + 32'd1;
      m_ph  <= bus.run ? 1 : 0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      cmp("state", 32'(bus.state), 32'(m_ph));
      cmp("pc", bus.pc, m_pc);
      cmp("ir", bus.ir, m_ir);
      cmp("instr_count", bus.instr_count, m_cnt);
      cmp("imem_req", 32'(bus.imem_req), 32'(m_ph == 1));
      cmp("alu_en", 32'(bus.alu_en), 32'(m_ph == 3));
      cmp("rf_we", 32'(bus.rf_we), 32'((m_ph == 4) && (bus.reg_dst != 5'd0)));
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start();
    bus.run = 1'b1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in its first FETCH cycle.
  task automatic instr(input logic [31:0] word, input logic [2:0] op, input logic j, input logic b,
                       input logic eq, input logic [31:0] im, input logic [4:0] dst,
                       input int delay, input logic run_after);
    int req_cycles = 0;
    int waits;
    bus.alu_op = op; bus.is_jump = j; bus.is_beq = b; bus.regs_equal = eq;
    bus.imm = im; bus.reg_dst = dst; bus.imem_rdata = word;
    for (int d = 0; d <= delay; d++) begin
      if (bus.imem_req) req_cycles++;
      bus.imem_ack = (d == delay);
      if (d > 0 && !run_after) bus.run = 1'b0;
      @(negedge clk);
    end
    lit("req_hold", req_cycles, delay + 1);
    bus.run = run_after;
    bus.imem_rdata = ~word;
    waits = (!j && !b && op >= 3'd2) ? 3 : 2;
    for (int w = 0; w < waits; w++) @(negedge clk);
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hABCD_0000;
    bus.alu_op = 3'd0; bus.is_jump = 1'b0; bus.is_beq = 1'b0; bus.imm = 32'd0;
    bus.reg_dst = 5'd0; bus.regs_equal = 1'b0;
    @(negedge clk);
    chk = 1'b1;
    @(negedge clk);
    lit("rst_state", 32'(bus.state), 32'd0);
    lit("rst_pc", bus.pc, 32'd0);
    lit("rst_ir", bus.ir, 32'd0);
    lit("rst_cnt", bus.instr_count, 32'd0);
    lit("rst_strobes", {29'd0, bus.imem_req, bus.alu_en, bus.rf_we}, 32'd0);
    rst = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    lit("idle_ack_ignored", bus.ir, 32'd0);

    start();
    instr(32'h2000_0003, 3'b010, 0, 0, 0, 32'd0, 5'd3, 0, 1);
    lit("add_pc", bus.pc, 32'd1);
    lit("add_cnt", bus.instr_count, 32'd1);
    lit("add_refetch", 32'(bus.state), 32'd1);
    repeat (4) instr(32'h0, 3'b000, 0, 0, 0, 32'd0, 5'd0, 0, 1);
    lit("noop_pc", bus.pc, 32'd5);
    instr(32'h4000_0000, 3'b000, 1, 0, 0, 32'hFFFF_FFFD, 5'd0, 0, 1);
    lit("jump_back_pc", bus.pc, 32'd2);
    instr(32'h4000_0001, 3'b000, 1, 0, 0, 32'd8, 5'd0, 0, 1);
    instr(32'h5000_0000, 3'b000, 0, 1, 1, 32'd4, 5'd0, 0, 1);
    lit("beq_taken_pc", bus.pc, 32'd14);
    instr(32'h4000_0002, 3'b000, 1, 0, 0, 32'hFFFF_FFFC, 5'd0, 0, 1);
    instr(32'h5000_0001, 3'b000, 0, 1, 0, 32'd4, 5'd0, 0, 1);
    lit("beq_not_taken_pc", bus.pc, 32'd11);
    instr(32'h6000_0000, 3'b000, 1, 1, 0, 32'd5, 5'd0, 0, 1);
    lit("jump_priority_pc", bus.pc, 32'd16);
    instr(32'h2000_0007, 3'b010, 0, 0, 0, 32'd0, 5'd7, 3, 0);
    lit("delayed_park", 32'(bus.state), 32'd0);
    lit("delayed_pc", bus.pc, 32'd17);
    lit("delayed_cnt", bus.instr_count, 32'd12);
    @(negedge clk);
    start();
    instr(32'h3000_0000, 3'b011, 0, 0, 0, 32'd1, 5'd0, 0, 1);
    lit("addi_r0_pc", bus.pc, 32'd18);
    instr(32'h1000_0000, 3'b001, 0, 0, 0, 32'd0, 5'd9, 0, 1);
    lit("undef_op_pc", bus.pc, 32'd19);
    instr(32'h4000_0003, 3'b000, 1, 0, 0, 32'hFFFF_FFEC, 5'd0, 0, 1);
    lit("pc_top", bus.pc, 32'hFFFF_FFFF);
    instr(32'h0, 3'b000, 0, 0, 0, 32'd0, 5'd0, 0, 0);
    lit("pc_wrap", bus.pc, 32'd0);
    lit("wrap_cnt", bus.instr_count, 32'd16);

    start();
    rst = 1'b1;
    @(negedge clk);
    lit("abort_state", 32'(bus.state), 32'd0);
    lit("abort_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b0; bus.run = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lit("late_ack_ir", bus.ir, 32'd0);
    lit("late_ack_state", 32'(bus.state), 32'd0);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
